// File: rtl/control_unit.sv
// control_unit: next-PC selection for a single-issue RV32I-style front end.
//
// Decodes a one-hot instruction bus and requests the register operands that
// control-flow instructions need. Once the requested operands are valid, it
// registers the address of the next instruction and a redirect flag.
//
// Ports
//   clk         sole clock; all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   pc          address of the instruction currently decoded
//   instr_bus   one-hot decoded instruction (bit 37 = illegal/none)
//   rs1_value   rs1 operand; rs1_valid marks it usable this cycle
//   rs2_value   rs2 operand; rs2_valid marks it usable this cycle
//   imm         sign-extended immediate
//   rs1_read    combinational request for rs1 (branches, JALR)
//   rs2_read    combinational request for rs2 (branches)
//   next_pc     registered address of the next instruction
//   pc_j_valid  registered; 1 on a taken branch or a jump
module control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic [37:0] instr_bus,
    input  logic [31:0] rs1_value,
    input  logic [31:0] rs2_value,
    input  logic        rs1_valid,
    input  logic        rs2_valid,
    input  logic [31:0] imm,
    output logic        rs1_read,
    output logic        rs2_read,
    output logic [31:0] next_pc,
    output logic        pc_j_valid
);
    logic        dec_ok;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        ready;
    logic        eq;
    logic        lt_s;
    logic        lt_u;
    logic        taken;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;
    logic [31:0] jalr_sum;
    logic [31:0] npc_d;
    logic        jv_d;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    // Anything else falls through as a plain sequential instruction.
    assign dec_ok    = (instr_bus != '0) && ((instr_bus & (instr_bus - 38'd1)) == '0);
    assign is_branch = dec_ok && (instr_bus[32:27] != '0);
    assign is_jal    = dec_ok && instr_bus[33];
    assign is_jalr   = dec_ok && instr_bus[34];

    assign rs1_read = rst_n && (is_branch || is_jalr);
    assign rs2_read = rst_n && is_branch;

    // A missing requested operand stalls; JAL and non-control never wait.
    assign ready = !((is_branch && !(rs1_valid && rs2_valid)) || (is_jalr && !rs1_valid));

    assign eq   = (rs1_value == rs2_value);
    assign lt_s = ($signed(rs1_value) < $signed(rs2_value));
    assign lt_u = (rs1_value < rs2_value);

    // Bus is known one-hot inside a branch, so each condition is gated by its own bit.
    assign taken = is_branch &&
                   ((instr_bus[27] &&  eq)   || (instr_bus[28] && !eq)   ||
                    (instr_bus[29] &&  lt_s) || (instr_bus[30] && !lt_s) ||
                    (instr_bus[31] &&  lt_u) || (instr_bus[32] && !lt_u));

    assign pc_plus4    = pc + 32'd4;
    assign pc_plus_imm = pc + imm;
    assign jalr_sum    = rs1_value + imm;

    always_comb begin
        npc_d = pc_plus4;
        jv_d  = 1'b0;
        if (!ready) begin
            npc_d = pc;
        end else if (taken || is_jal) begin
            npc_d = pc_plus_imm;
            jv_d  = 1'b1;
        end else if (is_jalr) begin
            npc_d = {jalr_sum[31:1], 1'b0};
            jv_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            next_pc    <= '0;
            pc_j_valid <= 1'b0;
        end else begin
            next_pc    <= npc_d;
            pc_j_valid <= jv_d;
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed literal vectors followed by
// randomized traffic, all compared against a behavioural next-PC model.
module tb_control_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [37:0] instr_bus;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        rs1_valid;
    logic        rs2_valid;
    logic [31:0] imm;
    logic        rs1_read;
    logic        rs2_read;
    logic [31:0] next_pc;
    logic        pc_j_valid;

    int tests = 0;
    int fails = 0;

    logic        have_exp = 1'b0;
    logic [31:0] exp_npc;
    logic        exp_jv;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instr_bus(instr_bus),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .rs1_valid(rs1_valid), .rs2_valid(rs2_valid), .imm(imm),
        .rs1_read(rs1_read), .rs2_read(rs2_read),
        .next_pc(next_pc), .pc_j_valid(pc_j_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: find the single set bit by counting, then apply the
    // instruction's architectural next-PC rule directly.
    function automatic void model(
        input  logic        rst, input logic [37:0] ib, input logic [31:0] p,
        input  logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
        input  logic        v1, input logic v2,
        output logic [31:0] npc, output logic jv, output logic rd1, output logic rd2);
        int     idx;
        int     cnt;
        logic   br;
        logic   tk;
        idx = -1;
        cnt = 0;
        for (int i = 0; i < 38; i++) if (ib[i]) begin cnt++; idx = i; end
        if (cnt != 1) idx = -1;
        br  = (idx >= 27) && (idx <= 32);
        rd1 = rst && (br || idx == 34);
        rd2 = rst && br;
        npc = p + 32'd4;
        jv  = 1'b0;
        tk  = 1'b0;
        case (idx)
            27: tk = (r1 == r2);
            28: tk = (r1 != r2);
            29: tk = ($signed(r1) <  $signed(r2));
            30: tk = ($signed(r1) >= $signed(r2));
            31: tk = (r1 <  r2);
            32: tk = (r1 >= r2);
            default: tk = 1'b0;
        endcase
        if (!rst) begin
            npc = 32'd0;
        end else if ((br && !(v1 && v2)) || (idx == 34 && !v1)) begin
            npc = p;
        end else if (tk || idx == 33) begin
            npc = p + im;
            jv  = 1'b1;
        end else if (idx == 34) begin
            npc = (r1 + im) & 32'hFFFF_FFFE;
            jv  = 1'b1;
        end
    endfunction

    // Capture what the edge must produce from the inputs it samples.
    always @(posedge clk) begin
        logic d1, d2;
        model(rst_n, instr_bus, pc, rs1_value, rs2_value, imm, rs1_valid, rs2_valid,
              exp_npc, exp_jv, d1, d2);
        have_exp = 1'b1;
    end

    always @(negedge clk) begin
        logic [31:0] n;
        logic        j, e1, e2;
        if (have_exp) begin
            chk("model next_pc", next_pc, exp_npc);
            chk("model pc_j_valid", {31'd0, pc_j_valid}, {31'd0, exp_jv});
            model(rst_n, instr_bus, pc, rs1_value, rs2_value, imm, rs1_valid, rs2_valid,
                  n, j, e1, e2);
            chk("model rs1_read", {31'd0, rs1_read}, {31'd0, e1});
            chk("model rs2_read", {31'd0, rs2_read}, {31'd0, e2});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [37:0] ib, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic v1, input logic v2);
        rst_n = r; instr_bus = ib; pc = p; rs1_value = r1; rs2_value = r2;
        imm = im; rs1_valid = v1; rs2_valid = v2;
    endtask

    function automatic logic [37:0] bit_at(input int i);
        logic [37:0] one;
        one = 38'd1;
        return one << i;
    endfunction

    initial begin
        logic [7:0]  ib8;
        logic [31:0] a;
        int          r;
        drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        step(); step();
        chk("reset next_pc", next_pc, 32'd0);
        chk("reset pc_j_valid", {31'd0, pc_j_valid}, 32'd0);

        drive(1'b1, bit_at(27), 32'd1, 32'd1, 32'd1, 32'd5, 1'b1, 1'b1);
        #1;
        chk("beq rs1_read", {31'd0, rs1_read}, 32'd1);
        chk("beq rs2_read", {31'd0, rs2_read}, 32'd1);
        step();
        chk("beq taken next_pc", next_pc, 32'd6);
        chk("beq taken jv", {31'd0, pc_j_valid}, 32'd1);

        drive(1'b1, bit_at(28), 32'd100, 32'd7, 32'd7, 32'd16, 1'b1, 1'b1);
        step();
        chk("bne not-taken next_pc", next_pc, 32'd104);
        chk("bne not-taken jv", {31'd0, pc_j_valid}, 32'd0);

        drive(1'b1, bit_at(29), 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd8, 1'b1, 1'b1);
        step();
        chk("blt signed next_pc", next_pc, 32'd8);
        chk("blt signed jv", {31'd0, pc_j_valid}, 32'd1);

        drive(1'b1, bit_at(31), 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd8, 1'b1, 1'b1);
        step();
        chk("bltu unsigned next_pc", next_pc, 32'd4);
        chk("bltu unsigned jv", {31'd0, pc_j_valid}, 32'd0);

        drive(1'b1, bit_at(34), 32'd0, 32'h1001, 32'd0, 32'd2, 1'b1, 1'b0);
        #1;
        chk("jalr rs1_read", {31'd0, rs1_read}, 32'd1);
        chk("jalr rs2_read", {31'd0, rs2_read}, 32'd0);
        step();
        chk("jalr next_pc", next_pc, 32'h1002);
        chk("jalr jv", {31'd0, pc_j_valid}, 32'd1);

        drive(1'b1, bit_at(27), 32'd40, 32'd3, 32'd3, 32'hFFFF_FFF8, 1'b0, 1'b1);
        step();
        chk("stall next_pc", next_pc, 32'd40);
        chk("stall jv", {31'd0, pc_j_valid}, 32'd0);
        rs1_valid = 1'b1;
        step();
        chk("resolve next_pc", next_pc, 32'd32);
        chk("resolve jv", {31'd0, pc_j_valid}, 32'd1);

        drive(1'b0, bit_at(27), 32'd40, 32'd3, 32'd3, 32'd4, 1'b0, 1'b0);
        #1;
        chk("reset rs1_read", {31'd0, rs1_read}, 32'd0);
        step();
        chk("reset mid-stall next_pc", next_pc, 32'd0);

        drive(1'b0, bit_at(33), 32'd20, 32'd0, 32'd0, 32'd12, 1'b1, 1'b1);
        step();
        chk("jal in reset next_pc", next_pc, 32'd0);
        chk("jal in reset jv", {31'd0, pc_j_valid}, 32'd0);

        drive(1'b1, bit_at(27) | bit_at(33), 32'd8, 32'd5, 32'd5, 32'd100, 1'b1, 1'b1);
        #1;
        chk("multi-hot rs1_read", {31'd0, rs1_read}, 32'd0);
        step();
        chk("multi-hot next_pc", next_pc, 32'd12);
        chk("multi-hot jv", {31'd0, pc_j_valid}, 32'd0);

        drive(1'b1, bit_at(33), 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, 1'b0, 1'b0);
        step();
        chk("jal wrap next_pc", next_pc, 32'd4);

        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      instr_bus = '0;
            else if (r == 1) instr_bus = bit_at($urandom_range(0, 37)) | bit_at($urandom_range(0, 37));
            else if (r < 12) instr_bus = bit_at($urandom_range(27, 34));
            else             instr_bus = bit_at($urandom_range(0, 37));
            rst_n     = ($urandom_range(0, 29) != 0);
            pc        = $urandom;
            a         = $urandom;
            rs1_value = a;
            rs2_value = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? ~a : $urandom);
            ib8       = 8'($urandom);
            imm       = {{24{ib8[7]}}, ib8};
            rs1_valid = ($urandom_range(0, 3) != 0);
            rs2_valid = ($urandom_range(0, 3) != 0);
            step();
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 pc  input  32  address of the instruction currently decoded.
REQ-005 instr_bus  input  38  one-hot decoded instruction.
- [9:0] ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND
- [18:10] ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI
- [23:19] LB,LH,LW,LBU,LHU
- [26:24] SB,SH,SW
- [32:27] BEQ,BNE,BLT,BGE,BLTU,BGEU
- 33 JAL, 34 JALR, 35 LUI, 36 AUIPC, 37 illegal/none.
REQ-006 rs1_value  input  32  signed rs1 operand.
REQ-007 rs2_value  input  32  signed rs2 operand.
REQ-008 rs1_valid  input  1  rs1_value is valid this cycle.
REQ-009 rs2_valid  input  1  rs2_value is valid this cycle.
REQ-010 imm  input  32  signed, already sign-extended immediate.
REQ-011 rs1_read  output  1  combinational request for rs1.
REQ-012 rs2_read  output  1  combinational request for rs2.
REQ-013 next_pc  output  32  registered address of next instruction.
REQ-014 pc_j_valid  output  1  registered; 1 = control-flow redirect (taken branch or jump).

Function
REQ-015 The decode SHALL be valid only when exactly one instr_bus bit is set; zero or multiple set bits SHALL be treated as a non-control instruction.
REQ-016 rs1_read SHALL be 1 for any valid branch (bits 27-32) or JALR; else 0.
REQ-017 rs2_read SHALL be 1 for any valid branch; else 0.
REQ-018 rs1_read and rs2_read SHALL be 0 while rst_n=0.
REQ-019 An instruction is ready when every operand it requests has its valid bit high; JAL and non-control instructions are always ready.
REQ-020 Not ready at a rising edge: next_pc<=pc, pc_j_valid<=0 (stall).
REQ-021 Ready, non-control instruction: next_pc<=pc+4, pc_j_valid<=0.
REQ-022 Branch conditions:
- BEQ rs1==rs2; BNE rs1!=rs2.
- BLT/BGE signed rs1<rs2 / rs1>=rs2.
- BLTU/BGEU unsigned rs1<rs2 / rs1>=rs2.
REQ-023 Taken branch: next_pc<=pc+imm, pc_j_valid<=1.
REQ-024 Not-taken branch: next_pc<=pc+4, pc_j_valid<=0.
REQ-025 JAL: next_pc<=pc+imm, pc_j_valid<=1.
REQ-026 JALR: next_pc<=(rs1+imm) with bit 0 cleared, pc_j_valid<=1.
REQ-027 All additions SHALL be 32-bit modulo 2^32 (wrap, no overflow flag).
REQ-028 No alignment check SHALL be applied beyond the JALR bit-0 clear.
REQ-029 Latency: outputs reflect the inputs sampled at the preceding rising edge, exactly one cycle.
REQ-030 The block SHALL hold no state other than the next_pc and pc_j_valid registers.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force next_pc<=0 and pc_j_valid<=0, overriding any instruction, including one in mid-stall.
REQ-032 The first edge with rst_n=1 SHALL evaluate the inputs normally; no stall state carries over.

Verification
REQ-033 BEQ taken: bit27, pc=1, rs1=rs2=1, imm=5, both valid.
- rs1_read=rs2_read=1.
- After the edge: next_pc=6, pc_j_valid=1.
REQ-034 BNE not taken: bit28, pc=100, rs1=rs2=7, imm=16 -> next_pc=104, pc_j_valid=0.
REQ-035 Signedness: rs1=-1, rs2=1, pc=0, imm=8.
- BLT -> next_pc=8, pc_j_valid=1.
- BLTU -> next_pc=4, pc_j_valid=0.
REQ-036 JALR: bit34, rs1=0x1001, imm=2 -> next_pc=0x1002, pc_j_valid=1, rs2_read=0.
REQ-037 Stall then resolve: BEQ, pc=40, rs1=rs2=3, imm=-8.
- rs1_valid=0 -> next_pc=40, pc_j_valid=0.
- Next cycle rs1_valid=1 -> next_pc=32, pc_j_valid=1.
REQ-038 Reset and decode errors:
- JAL with rst_n=0 -> next_pc=0, pc_j_valid=0.
- instr_bus with bits 27 and 33 set, pc=8 -> next_pc=12, pc_j_valid=0.
